cp0_exc_ctrl: RTL
=================

Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception controller for the five-stage MIPS pipeline. Sits beside the M stage, consumes the M-stage exception code from the exception coder and the external hardware interrupt lines, and decides each cycle whether to redirect fetch to the handler. It owns SR/Cause/EPC/PRId, executes mtc0/mfc0/eret, and sequences the normal↔handler (EXL) state.

Parameters:
HANDLER_PC, 32'h0000_4180, fetch redirect target on exception/interrupt
PRID_VAL, 32'h0000_2023, constant read value of PRId (reg 15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
M_pc  in  32  PC of instruction in M stage
M_bd  in  1  M instruction sits in a branch/jump delay slot
M_exc_valid  in  1  M instruction raised a synchronous exception
M_ExcCode  in  5  code accompanying M_exc_valid (4,5,8,10,12)
hwint  in  6  external interrupt lines, level-sensitive
cp0_we  in  1  mtc0 commit in M
cp0_addr  in  5  CP0 register number for mtc0/mfc0
cp0_wdata  in  32  mtc0 data
eret  in  1  eret commit in M
cp0_rdata  out  32  mfc0 read data (combinational)
req  out  1  flush pipeline, redirect fetch to HANDLER_PC
epc_out  out  32  current EPC, eret target
exl  out  1  SR.EXL, handler mode indicator

Behaviour:
- Reset (reset==0, async): SR=0, Cause=0, EPC=0; req=0, exl=0, epc_out=0, cp0_rdata=0 for addr 12/13/14.
- SR (12): IM=[15:10], EXL=[1], IE=[0]; other bits read 0. Cause (13): BD=[31], IP=[15:10], ExcCode=[6:2]; others 0. EPC (14): 32 bits. PRId (15): PRID_VAL. Other addresses read 0.
- Cause.IP <= hwint every cycle, regardless of other events.
- int_req = |(hwint & SR.IM) & SR.IE & ~SR.EXL (combinational, uses live hwint).
- exc_req = M_exc_valid & ~SR.EXL.
- req = int_req | exc_req, combinational, same cycle.
- State machine, 2 states held in SR.EXL: NORMAL (EXL=0), HANDLER (EXL=1).
  - NORMAL→HANDLER on posedge with req=1: EXL<=1; Cause.ExcCode <= int_req ? 0 : M_ExcCode (interrupt has priority); Cause.BD <= M_bd; EPC <= M_bd ? M_pc-4 : M_pc (32-bit wrap).
  - HANDLER→NORMAL on posedge with eret=1 and req=0: EXL<=0.
  - In HANDLER, further exceptions/interrupts are masked (req=0); no register update from them.
  - mtc0 to SR writing EXL also moves state.
- mtc0: on posedge with cp0_we=1 and req=0: addr 12 writes IM/EXL/IE only; addr 14 writes EPC; 13/15/others ignored.
- Simultaneous events, precedence: req > eret > mtc0. With req=1, eret and cp0_we are ignored that cycle (instruction is being flushed).
- eret with mtc0 in same cycle impossible by decode; not handled.
- epc_out = EPC register (no bypass; hazard unit stalls eret after mtc0 EPC).
- cp0_rdata combinational from registers before the current edge.
- Reset asserted mid-handler: immediately EXL=0, all registers cleared.

Test Plan:
- Reset low then high; read addr 12/13/14/15 → 0,0,0,32'h0000_2023; req=0, exl=0.
- M_exc_valid=1, M_ExcCode=5'd4, M_pc=32'h3008, M_bd=0 → req=1 same cycle; next cycle EPC=32'h3008, Cause[6:2]=4, exl=1, req=0 despite M_exc_valid still 1.
- Exception with M_bd=1, M_pc=32'h3010 → EPC=32'h300C, Cause[31]=1.
- mtc0 SR=32'h0000_0401 then hwint=6'b000001 → req=1; next cycle Cause[6:2]=0, Cause[10]=1, exl=1; also set M_exc_valid=1 with code 10 same cycle → ExcCode still 0.
- In HANDLER, eret=1 → exl=0 next cycle, epc_out unchanged; eret with req=1 in NORMAL → exl stays 1 after the edge.
- Assert reset low asynchronously while exl=1 mid-cycle → exl=0 and SR/Cause/EPC read 0 without a clock edge.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cp0_exc_ctrl
//
// Coprocessor-0 exception controller for the five-stage MIPS pipeline. It sits
// beside the M stage and decides each cycle whether the pipeline must be
// flushed and fetch redirected to the exception handler. It owns the SR,
// Cause, EPC and PRId registers, executes mtc0/mfc0/eret, and tracks the
// NORMAL/HANDLER mode, which is exactly SR.EXL.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   M_pc         PC of the instruction in M
//   M_bd         M instruction sits in a branch/jump delay slot
//   M_exc_valid  M instruction raised a synchronous exception
//   M_ExcCode    exception code accompanying M_exc_valid
//   hwint        external interrupt lines, level-sensitive
//   cp0_we       mtc0 commit in M
//   cp0_addr     CP0 register number for mtc0/mfc0
//   cp0_wdata    mtc0 write data
//   eret         eret commit in M
//   cp0_rdata    mfc0 read data (combinational, pre-edge register values)
//   req          flush pipeline and redirect fetch to HANDLER_PC
//   epc_out      current EPC, the eret target
//   exl          SR.EXL, handler mode indicator
//
// HANDLER_PC is the redirect target; the fetch stage consumes it when it sees
// req, so it is carried here only as the single point of definition.
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h0000_2023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_pc,
  input  logic        M_bd,
  input  logic        M_exc_valid,
  input  logic [4:0]  M_ExcCode,
  input  logic [5:0]  hwint,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret,
  output logic [31:0] cp0_rdata,
  output logic        req,
  output logic [31:0] epc_out,
  output logic        exl
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // The mode register is SR.EXL itself, so the encoding is fixed.
  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic int_req;
  logic exc_req;

  // Interrupts use the live hwint lines, not the registered Cause.IP copy.
  assign int_req = (|(hwint & sr_im_q)) & sr_ie_q & (state_q == NORMAL);
  assign exc_req = M_exc_valid & (state_q == NORMAL);
  assign req     = int_req | exc_req;

  assign exl     = (state_q == HANDLER);
  assign epc_out = epc_q;

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the if/case chain leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sr_im_d     = sr_im_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    cause_ip_d  = hwint;

    // Precedence req > eret > mtc0: a requesting instruction is flushed, so
    // any eret or mtc0 it carries must not commit.
    if (req) begin
      state_d     = HANDLER;
      cause_exc_d = int_req ? 5'd0 : M_ExcCode;
      cause_bd_d  = M_bd;
      // A delay-slot instruction restarts at its branch; wraps modulo 2^32.
      epc_d       = M_bd ? (M_pc - 32'd4) : M_pc;
    end else if (eret) begin
      state_d = NORMAL;
    end else if (cp0_we) begin
      case (cp0_addr)
        ADDR_SR: begin
          sr_im_d = cp0_wdata[15:10];
          state_d = state_e'(cp0_wdata[1]);
          sr_ie_d = cp0_wdata[0];
        end
        ADDR_EPC: epc_d = cp0_wdata;
        default:  ;
      endcase
    end
  end

  // NOTE: state registers update with non-blocking assignments so every
  // flop samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= NORMAL;
      sr_im_q     <= '0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      state_q     <= state_d;
      sr_im_q     <= sr_im_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      ADDR_SR: begin
        cp0_rdata[15:10] = sr_im_q;
        cp0_rdata[1]     = (state_q == HANDLER);
        cp0_rdata[0]     = sr_ie_q;
      end
      ADDR_CAUSE: begin
        cp0_rdata[31]    = cause_bd_q;
        cp0_rdata[15:10] = cause_ip_q;
        cp0_rdata[6:2]   = cause_exc_q;
      end
      ADDR_EPC:  cp0_rdata = epc_q;
      ADDR_PRID: cp0_rdata = PRID_VAL;
      default:   ;
    endcase
  end

endmodule
